// File: rtl/payment_change_dispenser.sv
// payment_change_dispenser: checkout change controller.
// Latches the change I-PG when a transaction starts, then releases one coin
// per clock (10-unit coins first, then 2-unit coins) and reports state,
// balances and a 26-character ASCII status message for the display.
module payment_change_dispenser (
    input  logic         clock,
    input  logic         reset,
    input  logic [4:0]   I,
    input  logic [4:0]   PG,
    output logic         DEZ,
    output logic         DOIS,
    output logic         FIM,
    output logic [4:0]   moneyToGive,
    output logic [4:0]   moneyState,
    output logic [2:0]   mainState,
    output logic [207:0] message
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_GIVE  = 3'd1;
    localparam logic [2:0] ST_DONE  = 3'd2;
    localparam logic [2:0] ST_ERROR = 3'd3;

    // Messages are left-justified and padded with spaces to 26 characters.
    localparam logic [207:0] MSG_IDLE  = {"INSIRA DINHEIRO",    {11{8'h20}}};
    localparam logic [207:0] MSG_GIVE  = {"A DAR TROCO",        {15{8'h20}}};
    localparam logic [207:0] MSG_DONE  = {"OBRIGADO",           {18{8'h20}}};
    localparam logic [207:0] MSG_ERROR = {"SALDO INSUFICIENTE", {8{8'h20}}};

    localparam logic [4:0] COIN_BIG   = 5'd10;
    localparam logic [4:0] COIN_SMALL = 5'd2;

    logic [2:0]   state_q, state_d;
    logic         dez_q, dez_d;
    logic         dois_q, dois_d;
    logic         fim_q, fim_d;
    logic [4:0]   give_q, give_d;
    logic [4:0]   bal_q, bal_d;
    logic [207:0] msg_q, msg_d;

    // Next-state, coin pulse and balance logic.
    always_comb begin
        state_d = state_q;
        dez_d   = 1'b0;
        dois_d  = 1'b0;
        fim_d   = fim_q;
        give_d  = give_q;
        bal_d   = bal_q;
        case (state_q)
            ST_IDLE: begin
                fim_d = 1'b0;
                // I=0 means no transaction; PG is don't-care then.
                if (I != 5'd0) begin
                    if (PG <= I) begin
                        give_d  = I - PG;
                        bal_d   = I - PG;
                        state_d = ST_GIVE;
                    end else begin
                        give_d  = 5'd0;
                        bal_d   = 5'd0;
                        state_d = ST_ERROR;
                    end
                end
            end
            ST_GIVE: begin
                if (bal_q >= COIN_BIG) begin
                    bal_d = bal_q - COIN_BIG;
                    dez_d = 1'b1;
                end else if (bal_q >= COIN_SMALL) begin
                    bal_d  = bal_q - COIN_SMALL;
                    dois_d = 1'b1;
                end else begin
                    // An odd residual of 1 cannot be paid out and stays visible.
                    fim_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // Wait for the customer to clear I so the same amount does not retrigger.
                fim_d = 1'b1;
                if (I == 5'd0) begin
                    fim_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_ERROR: begin
                fim_d = 1'b0;
                if (I == 5'd0) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                fim_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Status message follows the state being entered so it is registered with it.
    always_comb begin
        msg_d = MSG_IDLE;
        case (state_d)
            ST_GIVE:  msg_d = MSG_GIVE;
            ST_DONE:  msg_d = MSG_DONE;
            ST_ERROR: msg_d = MSG_ERROR;
            default:  msg_d = MSG_IDLE;
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            dez_q   <= 1'b0;
            dois_q  <= 1'b0;
            fim_q   <= 1'b0;
            give_q  <= 5'd0;
            bal_q   <= 5'd0;
            msg_q   <= MSG_IDLE;
        end else begin
            state_q <= state_d;
            dez_q   <= dez_d;
            dois_q  <= dois_d;
            fim_q   <= fim_d;
            give_q  <= give_d;
            bal_q   <= bal_d;
            msg_q   <= msg_d;
        end
    end

    assign DEZ         = dez_q;
    assign DOIS        = dois_q;
    assign FIM         = fim_q;
    assign moneyToGive = give_q;
    assign moneyState  = bal_q;
    assign mainState   = state_q;
    assign message     = msg_q;

endmodule

// File: tb/tb_payment_change_dispenser.sv
// tb_payment_change_dispenser: directed-vector bench for the change dispenser.
module tb_payment_change_dispenser;

    logic         clock;
    logic         reset;
    logic [4:0]   I;
    logic [4:0]   PG;
    logic         DEZ;
    logic         DOIS;
    logic         FIM;
    logic [4:0]   moneyToGive;
    logic [4:0]   moneyState;
    logic [2:0]   mainState;
    logic [207:0] message;

    localparam logic [207:0] EXP_MSG_IDLE = {"INSIRA DINHEIRO", {11{8'h20}}};
    localparam logic [207:0] EXP_MSG_GIVE = {"A DAR TROCO",     {15{8'h20}}};
    localparam logic [207:0] EXP_MSG_DONE = {"OBRIGADO",        {18{8'h20}}};

    int n_checks;
    int n_fail;

    int st, dz, ds, fm, mg, ms;
    int msg_idle_ok, msg_give_ok, msg_done_ok, msg_saldo_ok;

    assign st = int'(mainState);
    assign dz = int'(DEZ);
    assign ds = int'(DOIS);
    assign fm = int'(FIM);
    assign mg = int'(moneyToGive);
    assign ms = int'(moneyState);
    assign msg_idle_ok  = (message == EXP_MSG_IDLE) ? 1 : 0;
    assign msg_give_ok  = (message == EXP_MSG_GIVE) ? 1 : 0;
    assign msg_done_ok  = (message == EXP_MSG_DONE) ? 1 : 0;
    assign msg_saldo_ok = (message[207:168] == "SALDO") ? 1 : 0;

    payment_change_dispenser dut (
        .clock       (clock),
        .reset       (reset),
        .I           (I),
        .PG          (PG),
        .DEZ         (DEZ),
        .DOIS        (DOIS),
        .FIM         (FIM),
        .moneyToGive (moneyToGive),
        .moneyState  (moneyState),
        .mainState   (mainState),
        .message     (message)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle before sampling.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One complete transaction: trigger, coin stream, DONE hold, I=0 exit.
    task automatic run_txn(input int i, input int pg);
        int ch, nd, no, n, rem, paid;
        ch   = i - pg;
        nd   = ch / 10;
        no   = (ch % 10) / 2;
        n    = nd + no;
        paid = 0;
        I  = 5'(i);
        PG = 5'(pg);
        tick();
        check("trig_state", st, 1);
        check("trig_give", mg, ch);
        check("trig_bal", ms, ch);
        check("trig_nopulse", dz + ds, 0);
        check("trig_msg", msg_give_ok, 1);
        for (int k = 0; k < n; k++) begin
            tick();
            check("coin_dez", dz, (k < nd) ? 1 : 0);
            check("coin_dois", ds, (k >= nd) ? 1 : 0);
            rem = ch - 10 * ((k + 1 < nd) ? k + 1 : nd)
                     - 2 * ((k + 1 > nd) ? k + 1 - nd : 0);
            check("coin_bal", ms, rem);
            check("coin_fim", fm, 0);
            paid += 10 * dz + 2 * ds;
        end
        tick();
        check("done_fim", fm, 1);
        check("done_state", st, 2);
        check("done_nopulse", dz + ds, 0);
        check("done_resid", ms, ch % 2);
        check("done_msg", msg_done_ok, 1);
        check("paid_sum", paid + (ch % 2), ch);
        // Holding I must not retrigger.
        for (int k = 0; k < 2; k++) begin
            tick();
            check("hold_state", st, 2);
            check("hold_nopulse", dz + ds, 0);
            check("hold_fim", fm, 1);
        end
        I = 5'd0;
        tick();
        check("exit_state", st, 0);
        check("exit_fim", fm, 0);
        check("exit_give", mg, ch);
        check("exit_msg", msg_idle_ok, 1);
        $display("txn I=%0d PG=%0d change=%0d paid=%0d", i, pg, ch, paid);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b0;
        I     = 5'd0;
        PG    = 5'd0;
        tick();
        tick();
        check("rst_state", st, 0);
        check("rst_pulses", dz + ds + fm, 0);
        check("rst_give", mg, 0);
        check("rst_bal", ms, 0);
        check("rst_msg", msg_idle_ok, 1);
        reset = 1'b1;
        tick();
        check("idle_noi_state", st, 0);

        // Basic transactions, including the full 28 pattern and a residual of 1.
        run_txn(30, 28);
        run_txn(30, 2);
        run_txn(31, 0);
        run_txn(20, 20);

        // Sweep of even prices for I = 30, 20, 10.
        for (int a = 3; a >= 1; a--) begin
            for (int p = a * 10; p >= 2; p -= 2) begin
                run_txn(a * 10, p);
            end
        end

        // Insufficient payment.
        I  = 5'd10;
        PG = 5'd20;
        tick();
        check("err_state", st, 3);
        check("err_msg", msg_saldo_ok, 1);
        check("err_nopulse", dz + ds + fm, 0);
        check("err_give", mg, 0);
        tick();
        check("err_hold", st, 3);
        I = 5'd0;
        tick();
        check("err_exit", st, 0);
        $display("txn I=10 PG=20 error");

        // Reset in the middle of paying out 28.
        I  = 5'd30;
        PG = 5'd2;
        tick();
        tick();
        check("mid_dez", dz, 1);
        tick();
        reset = 1'b0;
        I     = 5'd0;
        tick();
        check("mrst_state", st, 0);
        check("mrst_pulses", dz + ds + fm, 0);
        check("mrst_give", mg, 0);
        check("mrst_bal", ms, 0);
        reset = 1'b1;
        tick();
        tick();
        check("mrst_quiet", dz + ds + st, 0);
        $display("txn I=30 PG=2 reset mid-give");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
